// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester-side request/response bundle for mem_port_arbiter
//
// One instance per requester. The requester drives the request fields and
// consumes the grant and the response; the arbiter does the opposite.
//
// Signals:
//   valid      requester -> arbiter  request present, held until ready
//   address    requester -> arbiter  word address, top two bits select region
//   writeData  requester -> arbiter  write data (ignored for reads)
//   we         requester -> arbiter  1 = write, 0 = read
//   ready      arbiter -> requester  grant, handshake when valid && ready
//   rsp_valid  arbiter -> requester  one-cycle response strobe
//   rsp_data   arbiter -> requester  response word, held between strobes
//   rsp_fault  arbiter -> requester  response belongs to a suppressed write
//
// Modports:
//   master  requester side
//   slave   arbiter side

interface mem_port_arbiter_if #(
    parameter int DATA_SIZE    = 16,
    parameter int ADDRESS_SIZE = 12
);
    logic                    valid;
    logic [ADDRESS_SIZE-1:0] address;
    logic [DATA_SIZE-1:0]    writeData;
    logic                    we;
    logic                    ready;
    logic                    rsp_valid;
    logic [DATA_SIZE-1:0]    rsp_data;
    logic                    rsp_fault;

    modport master (
        output valid,
        output address,
        output writeData,
        output we,
        input  ready,
        input  rsp_valid,
        input  rsp_data,
        input  rsp_fault
    );

    modport slave (
        input  valid,
        input  address,
        input  writeData,
        input  we,
        output ready,
        output rsp_valid,
        output rsp_data,
        output rsp_fault
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin sharing of RAM/IO port B between two requesters
//
// Requester 0 is the CPU data path, requester 1 the paint/blit engine. Both
// compete for a single address/data/write-enable bundle that fans out to
// port B of the RAM block and of the IO block. The pipeline accepts one
// request per cycle and answers every accepted request exactly two cycles
// after its handshake edge:
//
//   E0  handshake: winner's address/data registered onto the memory bus,
//       write enable qualified by region, tag/region/fault captured.
//   E1  RAM and IO register their outputs; tag/region/fault advance.
//   E2  returned word steered by region into the tagged requester's
//       response registers, rsp_valid strobes for one cycle.
//
// Address regions (top two address bits):
//   00  code, read-only     reads RAM; writes suppressed, flagged as fault
//   01  data RAM            reads/writes RAM
//   10  data RAM            reads/writes RAM
//   11  IO registers        reads IO; writes suppressed, flagged as fault
//
// Ports:
//   i_clk            single clock, all state on the rising edge
//   i_reset          asynchronous, active-high
//   r0, r1           requester bundles (mem_port_arbiter_if.slave)
//   o_mem_address    to RAM/IO port B address
//   o_mem_writeData  to RAM/IO port B write data
//   o_mem_we         to RAM/IO port B write enable
//   i_ram_out        RAM port B registered output
//   i_io_out         IO port B registered output

module mem_port_arbiter #(
    parameter int DATA_SIZE    = 16,
    parameter int ADDRESS_SIZE = 12
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    mem_port_arbiter_if.slave       r0,
    mem_port_arbiter_if.slave       r1,
    output logic [ADDRESS_SIZE-1:0] o_mem_address,
    output logic [DATA_SIZE-1:0]    o_mem_writeData,
    output logic                    o_mem_we,
    input  logic [DATA_SIZE-1:0]    i_ram_out,
    input  logic [DATA_SIZE-1:0]    i_io_out
);

    localparam logic [1:0] REGION_CODE = 2'b00;
    localparam logic [1:0] REGION_IO   = 2'b11;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------

    // Most recent winner. Resets to 1 so requester 0 wins the first tie.
    logic r_last;

    logic w_r0_ready;
    logic w_r1_ready;
    logic w_handshake;
    logic w_sel;

    // Ready is purely combinational from the valids and r_last, so it
    // follows the valids even while reset is held; the registers below
    // simply ignore the handshake during reset.
    assign w_r0_ready  = r0.valid && (!r1.valid || r_last);
    assign w_r1_ready  = r1.valid && (!r0.valid || !r_last);
    assign w_handshake = w_r0_ready || w_r1_ready;
    // Winner id; only meaningful when w_handshake is high.
    assign w_sel       = w_r1_ready;

    assign r0.ready = w_r0_ready;
    assign r1.ready = w_r1_ready;

    // ------------------------------------------------------------------
    // Winner request mux and region decode
    // ------------------------------------------------------------------

    logic [ADDRESS_SIZE-1:0] w_addr;
    logic [DATA_SIZE-1:0]    w_wdata;
    logic                    w_we;
    logic [1:0]              w_region;
    logic                    w_region_writable;
    logic                    w_fault;

    assign w_addr   = w_sel ? r1.address   : r0.address;
    assign w_wdata  = w_sel ? r1.writeData : r0.writeData;
    assign w_we     = w_sel ? r1.we        : r0.we;
    assign w_region = w_addr[ADDRESS_SIZE-1:ADDRESS_SIZE-2];

    // Only the two data-RAM regions accept writes.
    assign w_region_writable = (w_region != REGION_CODE) && (w_region != REGION_IO);
    assign w_fault           = w_we && !w_region_writable;

    // ------------------------------------------------------------------
    // Stage 1: memory bus drive and request bookkeeping
    // ------------------------------------------------------------------

    logic                    r_s1_valid;
    logic                    r_s1_tag;
    logic [1:0]              r_s1_region;
    logic                    r_s1_fault;
    logic [ADDRESS_SIZE-1:0] r_mem_address;
    logic [DATA_SIZE-1:0]    r_mem_writeData;
    logic                    r_mem_we;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_last          <= 1'b1;
            r_s1_valid      <= 1'b0;
            r_s1_tag        <= 1'b0;
            r_s1_region     <= 2'b00;
            r_s1_fault      <= 1'b0;
            r_mem_address   <= '0;
            r_mem_writeData <= '0;
            r_mem_we        <= 1'b0;
        end else if (w_handshake) begin
            r_last          <= w_sel;
            r_s1_valid      <= 1'b1;
            r_s1_tag        <= w_sel;
            r_s1_region     <= w_region;
            r_s1_fault      <= w_fault;
            r_mem_address   <= w_addr;
            r_mem_writeData <= w_wdata;
            r_mem_we        <= w_we && w_region_writable;
        end else begin
            // Idle cycle: address/data hold so the RAM output is stable,
            // but the write enable must drop so a write never repeats.
            r_s1_valid      <= 1'b0;
            r_mem_we        <= 1'b0;
        end
    end

    assign o_mem_address   = r_mem_address;
    assign o_mem_writeData = r_mem_writeData;
    assign o_mem_we        = r_mem_we;

    // ------------------------------------------------------------------
    // Stage 2: wait for the RAM/IO output registers
    // ------------------------------------------------------------------

    logic       r_s2_valid;
    logic       r_s2_tag;
    logic [1:0] r_s2_region;
    logic       r_s2_fault;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_s2_valid  <= 1'b0;
            r_s2_tag    <= 1'b0;
            r_s2_region <= 2'b00;
            r_s2_fault  <= 1'b0;
        end else begin
            r_s2_valid  <= r_s1_valid;
            r_s2_tag    <= r_s1_tag;
            r_s2_region <= r_s1_region;
            r_s2_fault  <= r_s1_fault;
        end
    end

    // ------------------------------------------------------------------
    // Response: steer by region, deliver to the tagged requester
    // ------------------------------------------------------------------

    logic [DATA_SIZE-1:0] w_rsp_word;
    logic                 w_rsp_to_r0;
    logic                 w_rsp_to_r1;

    assign w_rsp_word  = (r_s2_region == REGION_IO) ? i_io_out : i_ram_out;
    assign w_rsp_to_r0 = r_s2_valid && !r_s2_tag;
    assign w_rsp_to_r1 = r_s2_valid &&  r_s2_tag;

    logic                 r_r0_rsp_valid;
    logic [DATA_SIZE-1:0] r_r0_rsp_data;
    logic                 r_r0_rsp_fault;
    logic                 r_r1_rsp_valid;
    logic [DATA_SIZE-1:0] r_r1_rsp_data;
    logic                 r_r1_rsp_fault;

    // Data and fault only update on a strobe and hold otherwise.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_r0_rsp_valid <= 1'b0;
            r_r0_rsp_data  <= '0;
            r_r0_rsp_fault <= 1'b0;
        end else begin
            r_r0_rsp_valid <= w_rsp_to_r0;
            if (w_rsp_to_r0) begin
                r_r0_rsp_data  <= w_rsp_word;
                r_r0_rsp_fault <= r_s2_fault;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_r1_rsp_valid <= 1'b0;
            r_r1_rsp_data  <= '0;
            r_r1_rsp_fault <= 1'b0;
        end else begin
            r_r1_rsp_valid <= w_rsp_to_r1;
            if (w_rsp_to_r1) begin
                r_r1_rsp_data  <= w_rsp_word;
                r_r1_rsp_fault <= r_s2_fault;
            end
        end
    end

    assign r0.rsp_valid = r_r0_rsp_valid;
    assign r0.rsp_data  = r_r0_rsp_data;
    assign r0.rsp_fault = r_r0_rsp_fault;
    assign r1.rsp_valid = r_r1_rsp_valid;
    assign r1.rsp_data  = r_r1_rsp_data;
    assign r1.rsp_fault = r_r1_rsp_fault;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter

module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic [11:0] mem_address;
    logic [15:0] mem_writeData;
    logic        mem_we;
    logic [15:0] ram_out;
    logic [15:0] io_out;

    logic [15:0] ram [0:4095];
    logic [15:0] mouse_x;
    logic        lmb;

    int checks;
    int failures;
    int we_pulses;

    mem_port_arbiter_if #(.DATA_SIZE(16), .ADDRESS_SIZE(12)) r0_if ();
    mem_port_arbiter_if #(.DATA_SIZE(16), .ADDRESS_SIZE(12)) r1_if ();

    mem_port_arbiter #(.DATA_SIZE(16), .ADDRESS_SIZE(12)) dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .r0              (r0_if),
        .r1              (r1_if),
        .o_mem_address   (mem_address),
        .o_mem_writeData (mem_writeData),
        .o_mem_we        (mem_we),
        .i_ram_out       (ram_out),
        .i_io_out        (io_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM port B: registered output, write-first.
    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_address] <= mem_writeData;
            ram_out          <= mem_writeData;
        end else begin
            ram_out <= ram[mem_address];
        end
    end

    // IO port B: 0xFF8 mouse_x, 0xFF9 buttons (lmb on bit 2), others 0.
    always @(posedge clk) begin
        if (mem_address == 12'hFF8)      io_out <= mouse_x;
        else if (mem_address == 12'hFF9) io_out <= {13'b0, lmb, 2'b00};
        else                             io_out <= 16'h0000;
    end

    always @(negedge clk) begin
        if (mem_we === 1'b1) we_pulses <= we_pulses + 1;
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset       = 1'b1;
        r0_if.valid = 1'b0;
        r1_if.valid = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    // Issue one request from a single requester starting at a negedge and
    // wait (bounded) for its response. lat counts negedges after the handshake.
    task automatic single_req(input int id, input logic [11:0] addr, input logic [15:0] wd,
                              input logic we, output logic [15:0] d, output logic f,
                              output int lat, output logic granted);
        if (id == 0) begin
            r0_if.address = addr; r0_if.writeData = wd; r0_if.we = we; r0_if.valid = 1'b1;
        end else begin
            r1_if.address = addr; r1_if.writeData = wd; r1_if.we = we; r1_if.valid = 1'b1;
        end
        #1;
        granted = (id == 0) ? r0_if.ready : r1_if.ready;
        step();
        r0_if.valid = 1'b0;
        r1_if.valid = 1'b0;
        lat = 0;
        d   = 16'hxxxx;
        f   = 1'bx;
        for (int n = 1; n <= 8; n++) begin
            if ((id == 0 && r0_if.rsp_valid === 1'b1) || (id == 1 && r1_if.rsp_valid === 1'b1)) begin
                lat = n;
                d   = (id == 0) ? r0_if.rsp_data  : r1_if.rsp_data;
                f   = (id == 0) ? r0_if.rsp_fault : r1_if.rsp_fault;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        r0_if.valid = 1'b0;
        r1_if.valid = 1'b0;
        step();
        checks++;
        if (mem_we !== 1'b0 || mem_address !== 12'h000 || mem_writeData !== 16'h0000) begin
            failures++;
            $display("FAIL reset_mem: we=%b addr=%h wd=%h required 0 000 0000", mem_we, mem_address, mem_writeData);
        end
        checks++;
        if (r0_if.rsp_valid !== 1'b0 || r1_if.rsp_valid !== 1'b0 || r0_if.rsp_data !== 16'h0 ||
            r1_if.rsp_data !== 16'h0 || r0_if.rsp_fault !== 1'b0 || r1_if.rsp_fault !== 1'b0) begin
            failures++;
            $display("FAIL reset_rsp: v=%b%b d=%h/%h f=%b%b required all zero", r0_if.rsp_valid,
                     r1_if.rsp_valid, r0_if.rsp_data, r1_if.rsp_data, r0_if.rsp_fault, r1_if.rsp_fault);
        end
        r0_if.valid = 1'b1;
        #1;
        checks++;
        if (r0_if.ready !== 1'b1 || r1_if.ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready_follows_valid: r0_ready=%b r1_ready=%b required 1 0", r0_if.ready, r1_if.ready);
        end
        step();
        r0_if.valid = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_single_read();
        logic [15:0] d; logic f; int lat; logic g; int w0;
        w0 = we_pulses;
        single_req(0, 12'h005, 16'h0000, 1'b0, d, f, lat, g);
        checks++;
        if (g !== 1'b1 || lat != 3 || d !== 16'h1234 || f !== 1'b0) begin
            failures++;
            $display("FAIL single_read: grant=%b lat=%0d data=%h fault=%b required 1 3 1234 0", g, lat, d, f);
        end
        checks++;
        if (we_pulses != w0) begin
            failures++;
            $display("FAIL single_read_we: pulses=%0d required 0", we_pulses - w0);
        end
    endtask

    task automatic test_write_read();
        logic [15:0] d; logic f; int lat; logic g; int w0;
        w0 = we_pulses;
        single_req(1, 12'h400, 16'hBEEF, 1'b1, d, f, lat, g);
        checks++;
        if (g !== 1'b1 || lat != 3 || d !== 16'hBEEF || f !== 1'b0) begin
            failures++;
            $display("FAIL write_rsp: grant=%b lat=%0d data=%h fault=%b required 1 3 beef 0", g, lat, d, f);
        end
        checks++;
        if (we_pulses != w0 + 1) begin
            failures++;
            $display("FAIL write_we_pulses: got %0d required 1", we_pulses - w0);
        end
        single_req(1, 12'h400, 16'h0000, 1'b0, d, f, lat, g);
        checks++;
        if (lat != 3 || d !== 16'hBEEF || f !== 1'b0) begin
            failures++;
            $display("FAIL read_after_write: lat=%0d data=%h fault=%b required 3 beef 0", lat, d, f);
        end
    endtask

    task automatic test_contention();
        int gi; int ri; int id;
        logic [15:0] expd;
        apply_reset();
        r0_if.address = 12'h005; r0_if.we = 1'b0; r0_if.writeData = 16'h0;
        r1_if.address = 12'h400; r1_if.we = 1'b0; r1_if.writeData = 16'h0;
        gi = 0;
        ri = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            r0_if.valid = (cyc < 6);
            r1_if.valid = (cyc < 6);
            #1;
            if (cyc < 6) begin
                checks++;
                if (r0_if.ready !== (gi % 2 == 0) || r1_if.ready !== (gi % 2 == 1)) begin
                    failures++;
                    $display("FAIL contention_grant[%0d]: ready=%b%b required winner %0d", gi,
                             r0_if.ready, r1_if.ready, gi % 2);
                end
                gi++;
            end
            if (r0_if.rsp_valid === 1'b1 || r1_if.rsp_valid === 1'b1) begin
                id   = ri % 2;
                expd = (id == 0) ? 16'h1234 : 16'hBEEF;
                checks++;
                if (r0_if.rsp_valid !== (id == 0) || r1_if.rsp_valid !== (id == 1) ||
                    ((id == 0) ? r0_if.rsp_data : r1_if.rsp_data) !== expd) begin
                    failures++;
                    $display("FAIL contention_rsp[%0d]: valid=%b%b data=%h/%h required requester %0d data %h",
                             ri, r0_if.rsp_valid, r1_if.rsp_valid, r0_if.rsp_data, r1_if.rsp_data, id, expd);
                end
                ri++;
            end
            step();
        end
        checks++;
        if (ri != 6) begin
            failures++;
            $display("FAIL contention_rsp_count: got %0d required 6", ri);
        end
    endtask

    task automatic test_protected_writes();
        logic [15:0] d; logic f; int lat; logic g; int w0;
        mouse_x = 16'h0555;
        w0 = we_pulses;
        single_req(0, 12'h010, 16'hAAAA, 1'b1, d, f, lat, g);
        checks++;
        if (lat != 3 || d !== 16'hC0DE || f !== 1'b1) begin
            failures++;
            $display("FAIL protect_code: lat=%0d data=%h fault=%b required 3 c0de 1", lat, d, f);
        end
        single_req(0, 12'hFF8, 16'hAAAA, 1'b1, d, f, lat, g);
        checks++;
        if (lat != 3 || d !== 16'h0555 || f !== 1'b1) begin
            failures++;
            $display("FAIL protect_io: lat=%0d data=%h fault=%b required 3 0555 1", lat, d, f);
        end
        checks++;
        if (we_pulses != w0) begin
            failures++;
            $display("FAIL protect_we: pulses=%0d required 0", we_pulses - w0);
        end
        single_req(0, 12'h010, 16'h0000, 1'b0, d, f, lat, g);
        checks++;
        if (lat != 3 || d !== 16'hC0DE || f !== 1'b0) begin
            failures++;
            $display("FAIL protect_readback: lat=%0d data=%h fault=%b required 3 c0de 0", lat, d, f);
        end
    endtask

    task automatic test_back_to_back_io();
        logic h0, h1, got0, got1;
        logic [15:0] d0, d1;
        logic f0, f1;
        mouse_x = 16'h0123;
        lmb     = 1'b1;
        r0_if.address = 12'hFF9; r0_if.we = 1'b0; r0_if.writeData = 16'h0; r0_if.valid = 1'b1;
        r1_if.address = 12'hFF8; r1_if.we = 1'b0; r1_if.writeData = 16'h0; r1_if.valid = 1'b1;
        got0 = 1'b0; got1 = 1'b0; d0 = 16'h0; d1 = 16'h0; f0 = 1'b0; f1 = 1'b0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (r0_if.rsp_valid === 1'b1) begin got0 = 1'b1; d0 = r0_if.rsp_data; f0 = r0_if.rsp_fault; end
            if (r1_if.rsp_valid === 1'b1) begin got1 = 1'b1; d1 = r1_if.rsp_data; f1 = r1_if.rsp_fault; end
            #1;
            h0 = r0_if.valid && r0_if.ready;
            h1 = r1_if.valid && r1_if.ready;
            step();
            if (h0) r0_if.valid = 1'b0;
            if (h1) r1_if.valid = 1'b0;
        end
        r0_if.valid = 1'b0;
        r1_if.valid = 1'b0;
        checks++;
        if (got1 !== 1'b1 || d1 !== 16'h0123 || f1 !== 1'b0) begin
            failures++;
            $display("FAIL io_mouse_x: got=%b data=%h fault=%b required 1 0123 0", got1, d1, f1);
        end
        checks++;
        if (got0 !== 1'b1 || d0 !== 16'h0004 || f0 !== 1'b0) begin
            failures++;
            $display("FAIL io_buttons: got=%b data=%h fault=%b required 1 0004 0", got0, d0, f0);
        end
    endtask

    task automatic test_reset_midflight();
        logic seen;
        r0_if.address = 12'h005; r0_if.we = 1'b0; r0_if.writeData = 16'h0; r0_if.valid = 1'b1;
        #1;
        checks++;
        if (r0_if.ready !== 1'b1) begin
            failures++;
            $display("FAIL midflight_accept: ready=%b required 1", r0_if.ready);
        end
        step();
        r0_if.valid = 1'b0;
        reset = 1'b1;
        #1;
        checks++;
        if (mem_address !== 12'h000 || mem_we !== 1'b0) begin
            failures++;
            $display("FAIL midflight_async_clear: addr=%h we=%b required 000 0", mem_address, mem_we);
        end
        step();
        reset = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 6; n++) begin
            if (r0_if.rsp_valid === 1'b1 || r1_if.rsp_valid === 1'b1) seen = 1'b1;
            step();
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL midflight_dropped: response seen=%b required 0", seen);
        end
        r1_if.address = 12'h400; r1_if.we = 1'b0;
        r0_if.valid = 1'b1;
        r1_if.valid = 1'b1;
        #1;
        checks++;
        if (r0_if.ready !== 1'b1 || r1_if.ready !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_first_grant: ready=%b%b required 10", r0_if.ready, r1_if.ready);
        end
        step();
        #1;
        checks++;
        if (r0_if.ready !== 1'b0 || r1_if.ready !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_second_grant: ready=%b%b required 01", r0_if.ready, r1_if.ready);
        end
        step();
        r0_if.valid = 1'b0;
        r1_if.valid = 1'b0;
        repeat (4) step();
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        we_pulses = 0;
        reset     = 1'b1;
        mouse_x   = 16'h0000;
        lmb       = 1'b0;
        ram_out   = 16'h0000;
        io_out    = 16'h0000;
        r0_if.valid = 1'b0; r0_if.address = 12'h0; r0_if.writeData = 16'h0; r0_if.we = 1'b0;
        r1_if.valid = 1'b0; r1_if.address = 12'h0; r1_if.writeData = 16'h0; r1_if.we = 1'b0;
        for (int i = 0; i < 4096; i++) ram[i] = 16'h0000;
        ram[12'h005] = 16'h1234;
        ram[12'h010] = 16'hC0DE;
        @(negedge clk);

        test_reset();
        test_single_read();
        test_write_read();
        test_contention();
        test_protected_writes();
        test_back_to_back_io();
        test_reset_midflight();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
